fire_sequencer: RTL

FIRE_SEQUENCER -- requirements
Module: fire_sequencer

---
 rtl/fire_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fire_sequencer.sv
// Weapon fire sequencer: trigger -> recoil animation -> damage handshake, plus magazine reload.
// Responds one cycle after the trigger; dmg_valid holds until dmg_ack, and requests made while busy are dropped.
module fire_sequencer #(
   parameter int AMMO_MAX     = 8,
   parameter int FRAME_TICKS  = 4,
   parameter int RELOAD_TICKS = 16,
   parameter int DAMAGE       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fire_req,
   input  logic       reload_req,
   input  logic       target_hit,
   input  logic       dmg_ack,
   output logic [1:0] seq_state,
   output logic [1:0] anim_frame,
   output logic [3:0] ammo,
   output logic       busy,
   output logic       dmg_valid,
   output logic [3:0] dmg_amount,
   output logic       dry_fire
);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ANIM   = 2'b01;
   localparam logic [1:0] ST_DAMAGE = 2'b10;
   localparam logic [1:0] ST_RELOAD = 2'b11;

   localparam logic [7:0] FRAME_LAST  = 8'(FRAME_TICKS - 1);
   localparam logic [7:0] RELOAD_LAST = 8'(RELOAD_TICKS - 1);
   localparam logic [3:0] AMMO_FULL   = 4'(AMMO_MAX);
   localparam logic [3:0] DMG_VAL     = 4'(DAMAGE);

   logic [1:0] state_q, state_d;
   logic [1:0] frame_q, frame_d;
   logic [7:0] tick_q, tick_d;
   logic [3:0] ammo_q, ammo_d;
   logic       hit_l_q, hit_l_d;
   logic       dry_fire_q, dry_fire_d;
   logic       busy_q, busy_d;
   logic       dmg_valid_q, dmg_valid_d;
   logic [3:0] dmg_amount_q, dmg_amount_d;

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      tick_d     = tick_q;
      ammo_d     = ammo_q;
      hit_l_d    = hit_l_q;
      dry_fire_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Fire wins over reload; an empty trigger pull only reports a dry fire.
            if (fire_req) begin
               if (ammo_q != 4'd0) begin
                  state_d = ST_ANIM;
                  ammo_d  = ammo_q - 4'd1;
                  hit_l_d = target_hit;
                  frame_d = 2'd0;
                  tick_d  = 8'd0;
               end else begin
                  dry_fire_d = 1'b1;
               end
            end else if (reload_req && (ammo_q < AMMO_FULL)) begin
               state_d = ST_RELOAD;
               tick_d  = 8'd0;
            end
         end
         ST_ANIM: begin
            if (tick_q == FRAME_LAST) begin
               tick_d = 8'd0;
               if (frame_q == 2'd3) begin
                  frame_d = 2'd0;
                  state_d = hit_l_q ? ST_DAMAGE : ST_IDLE;
               end else begin
                  frame_d = frame_q + 2'd1;
               end
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end
         ST_DAMAGE: begin
            if (dmg_ack) begin
               state_d = ST_IDLE;
            end
         end
         ST_RELOAD: begin
            if (tick_q == RELOAD_LAST) begin
               tick_d  = 8'd0;
               ammo_d  = AMMO_FULL;
               state_d = ST_IDLE;
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            frame_d = 2'd0;
            tick_d  = 8'd0;
         end
      endcase

      // Status outputs are registered from the next state so they line up with seq_state.
      busy_d       = (state_d != ST_IDLE);
      dmg_valid_d  = (state_d == ST_DAMAGE);
      dmg_amount_d = dmg_valid_d ? DMG_VAL : 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         frame_q      <= 2'd0;
         tick_q       <= 8'd0;
         ammo_q       <= AMMO_FULL;
         hit_l_q      <= 1'b0;
         dry_fire_q   <= 1'b0;
         busy_q       <= 1'b0;
         dmg_valid_q  <= 1'b0;
         dmg_amount_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         tick_q       <= tick_d;
         ammo_q       <= ammo_d;
         hit_l_q      <= hit_l_d;
         dry_fire_q   <= dry_fire_d;
         busy_q       <= busy_d;
         dmg_valid_q  <= dmg_valid_d;
         dmg_amount_q <= dmg_amount_d;
      end
   end

   assign seq_state  = state_q;
   assign anim_frame = frame_q;
   assign ammo       = ammo_q;
   assign busy       = busy_q;
   assign dmg_valid  = dmg_valid_q;
   assign dmg_amount = dmg_amount_q;
   assign dry_fire   = dry_fire_q;

endmodule
